// File: rtl/rriot_bus_master.sv
// ---------------------------------------------------------------------------
// rriot_bus_master
// Bus initiator for the 6530 RRIOT register/RAM/ROM map. It accepts one host
// request at a time over valid/ready and runs the matching 6502-style bus
// cycle. A read samples registered data when the peripheral raises bus_oe.
// The block then holds a response (read data, or an error on timeout) until
// the host takes it.
//
// Ports
//   phi2, rst_n               clock (rising edge), async active-low reset
//   req_valid/req_ready       host request handshake (ready is combinational)
//   req_we, req_rom           1=write / 1=ROM space (drives bus_rs_n low)
//   req_addr[9:0], req_wdata  target address and write data
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata[7:0], rsp_err   read data (0x00 write, 0xFF timeout), timeout flag
//   bus_cs1_n, bus_rs_n       chip select / ROM select, active low
//   bus_we_n                  0 = write cycle
//   bus_addr, bus_wdata       address and data to the peripheral
//   bus_rdata, bus_oe         data from the peripheral and its valid strobe
//
// States
//   state     | meaning
//   S_IDLE    | ready for a request, bus deselected
//   S_WR      | single write strobe cycle
//   S_RD_ADDR | read address phase, wait counter cleared
//   S_RD_WAIT | read select held, waiting for bus_oe or timeout
//   S_RESP    | response presented, waiting for rsp_ready
// ---------------------------------------------------------------------------
module rriot_bus_master #(
    parameter int TIMEOUT = 4
) (
    input  logic       phi2,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic       req_rom,
    input  logic [9:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       bus_cs1_n,
    output logic       bus_rs_n,
    output logic       bus_we_n,
    output logic [9:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    input  logic       bus_oe
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cs1_n_q, cs1_n_d;
    logic             rs_n_q, rs_n_d;
    logic             we_n_q, we_n_d;
    logic [9:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             req_fire;

    assign req_ready = rst_n & (state_q == S_IDLE);
    assign req_fire  = req_valid & req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rs_n_d  = rs_n_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rs_n_d  = ~req_rom;
                    state_d = req_we ? S_WR : S_RD_ADDR;
                end
            end
            S_WR: begin
                rdata_d = 8'h00;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RD_ADDR: begin
                cnt_d   = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // bus_oe is checked first so data arriving on the last allowed
                // cycle still wins over the timeout.
                if (bus_oe) begin
                    rdata_d = bus_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = 8'hFF;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus strobes are decoded from the next state so they come from flops
        // and line up with the state they belong to.
        if (state_d == S_RESP) begin
            rs_n_d = 1'b1;
        end
        cs1_n_d     = !((state_d == S_WR) || (state_d == S_RD_ADDR) || (state_d == S_RD_WAIT));
        we_n_d      = (state_d != S_WR);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cs1_n_q     <= 1'b1;
            rs_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cs1_n_q     <= cs1_n_d;
            rs_n_q      <= rs_n_d;
            we_n_q      <= we_n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus_cs1_n = cs1_n_q;
    assign bus_rs_n  = rs_n_q;
    assign bus_we_n  = we_n_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_rriot_bus_master.sv
// ---------------------------------------------------------------------------
// tb_rriot_bus_master
// Self-checking bench for rriot_bus_master. Each transaction's expected bus
// activity and response are worked out in advance from the access rules:
//   write               -> 1 select cycle, response 0x00 / no error
//   read, oe after d    -> 1 address cycle + (d+1) wait cycles, bus data
//   read, oe never      -> 1 address cycle + TIMEOUT wait cycles, 0xFF / error
// Inputs change on the falling edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_rriot_bus_master;

    localparam int TIMEOUT = 4;
    localparam int NO_OE   = 99;

    logic       phi2;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic       req_rom;
    logic [9:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       bus_cs1_n;
    logic       bus_rs_n;
    logic       bus_we_n;
    logic [9:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_oe;

    int n_chk;
    int n_fail;

    typedef struct {
        logic       we;
        logic       rom;
        logic [9:0] addr;
        logic [7:0] wd;
        int         oe_dly;
        logic [7:0] rd;
        int         rdy_dly;
    } txn_t;

    rriot_bus_master #(.TIMEOUT(TIMEOUT)) dut (
        .phi2      (phi2),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_rom   (req_rom),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus_cs1_n (bus_cs1_n),
        .bus_rs_n  (bus_rs_n),
        .bus_we_n  (bus_we_n),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_oe    (bus_oe)
    );

    initial begin
        phi2 = 1'b0;
        forever #5 phi2 = ~phi2;
    end

    // Runs one transaction; called at a falling edge with the DUT idle.
    // With keep=1 the next request (nx) is presented while this one is busy
    // and must not be taken until the response handshake completes.
    task automatic run_txn(input txn_t t, input bit keep, input txn_t nx);
        int         n_bus;
        logic [7:0] exp_rd;
        logic       exp_err;
        logic [23:0] got_bus, exp_bus;
        logic [30:0] got_rsp, exp_rsp;

        if (t.we) begin
            n_bus = 1; exp_rd = 8'h00; exp_err = 1'b0;
        end else if (t.oe_dly < TIMEOUT) begin
            n_bus = 2 + t.oe_dly; exp_rd = t.rd; exp_err = 1'b0;
        end else begin
            n_bus = 1 + TIMEOUT; exp_rd = 8'hFF; exp_err = 1'b1;
        end

        n_chk++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_before_req: req_ready=%b rsp_valid=%b, required 1 0", req_ready, rsp_valid);
        end
        req_valid = 1'b1;
        req_we    = t.we;
        req_rom   = t.rom;
        req_addr  = t.addr;
        req_wdata = t.wd;
        @(negedge phi2);

        for (int k = 0; k < n_bus; k++) begin
            if (keep) begin
                req_valid = 1'b1;
                req_we    = nx.we;
                req_rom   = nx.rom;
                req_addr  = nx.addr;
                req_wdata = nx.wd;
            end else begin
                req_valid = 1'b0;
                req_we    = 1'($urandom);
                req_rom   = 1'($urandom);
                req_addr  = 10'($urandom);
                req_wdata = 8'($urandom);
            end
            rsp_ready = 1'($urandom);
            got_bus = {bus_cs1_n, bus_we_n, bus_rs_n, bus_addr, bus_wdata, rsp_valid, req_ready};
            exp_bus = {1'b0, ~t.we, ~t.rom, t.addr, t.wd, 1'b0, 1'b0};
            n_chk++;
            if (got_bus !== exp_bus) begin
                n_fail++;
                $display("FAIL bus_cycle k=%0d we=%b: {cs,we,rs,addr,wd,rv,rr}=%h, required %h", k, t.we, got_bus, exp_bus);
            end
            if (k == 0) begin
                bus_oe    = 1'($urandom);
                bus_rdata = 8'($urandom);
            end else begin
                bus_oe    = (k - 1 == t.oe_dly);
                bus_rdata = bus_oe ? t.rd : 8'($urandom);
            end
            @(negedge phi2);
        end

        for (int w = 0; w <= t.rdy_dly; w++) begin
            bus_oe    = 1'($urandom);
            bus_rdata = 8'($urandom);
            got_rsp = {bus_cs1_n, bus_we_n, bus_rs_n, rsp_valid, rsp_err, rsp_rdata, req_ready, bus_addr, bus_wdata};
            exp_rsp = {1'b1, 1'b1, 1'b1, 1'b1, exp_err, exp_rd, 1'b0, t.addr, t.wd};
            n_chk++;
            if (got_rsp !== exp_rsp) begin
                n_fail++;
                $display("FAIL resp_hold w=%0d: {cs,we,rs,rv,err,rd,rr,addr,wd}=%h, required %h", w, got_rsp, exp_rsp);
            end
            rsp_ready = (w == t.rdy_dly);
            @(negedge phi2);
        end
        rsp_ready = 1'b0;
        bus_oe    = 1'b0;

        n_chk++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || bus_cs1_n !== 1'b1) begin
            n_fail++;
            $display("FAIL after_handshake: rsp_valid=%b req_ready=%b cs1_n=%b, required 0 1 1", rsp_valid, req_ready, bus_cs1_n);
        end
        if (!keep) begin
            req_valid = 1'b0;
        end
    endtask

    function automatic txn_t mk(input logic we, input logic rom, input logic [9:0] addr,
                                input logic [7:0] wd, input int oe_dly, input logic [7:0] rd,
                                input int rdy_dly);
        txn_t t;
        t.we = we; t.rom = rom; t.addr = addr; t.wd = wd;
        t.oe_dly = oe_dly; t.rd = rd; t.rdy_dly = rdy_dly;
        return t;
    endfunction

    task automatic test_reset();
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_rom   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        bus_rdata = '0;
        bus_oe    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bus_cs1_n, bus_rs_n, bus_we_n, bus_addr, bus_wdata, rsp_valid, rsp_rdata, rsp_err, req_ready}
            !== {1'b1, 1'b1, 1'b1, 10'h0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: cs=%b rs=%b we=%b addr=%h wd=%h rv=%b rd=%h err=%b rr=%b, required 1 1 1 000 00 0 00 0 0",
                     bus_cs1_n, bus_rs_n, bus_we_n, bus_addr, bus_wdata, rsp_valid, rsp_rdata, rsp_err, req_ready);
        end
        repeat (2) @(negedge phi2);
        rst_n = 1'b1;
        @(negedge phi2);
        n_chk++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || bus_cs1_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: req_ready=%b rsp_valid=%b cs1_n=%b, required 1 0 1", req_ready, rsp_valid, bus_cs1_n);
        end
    endtask

    task automatic test_write();
        run_txn(mk(1'b1, 1'b0, 10'h000, 8'hA5, 0, 8'h00, 0), 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_read();
        run_txn(mk(1'b0, 1'b0, 10'h001, 8'h00, 0, 8'h3C, 0), 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
        run_txn(mk(1'b0, 1'b0, 10'h155, 8'h12, TIMEOUT - 1, 8'hC3, 1), 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_timeout();
        run_txn(mk(1'b0, 1'b0, 10'h2AA, 8'h00, NO_OE, 8'h00, 0), 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_backpressure();
        txn_t a;
        txn_t b;
        a = mk(1'b1, 1'b0, 10'h123, 8'h5A, 0, 8'h00, 5);
        b = mk(1'b0, 1'b0, 10'h321, 8'h77, 1, 8'h99, 0);
        run_txn(a, 1'b1, b);
        run_txn(b, 1'b0, a);
    endtask

    task automatic test_rom();
        run_txn(mk(1'b0, 1'b1, 10'h3FF, 8'h00, 0, 8'h3C, 0), 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic test_back_to_back();
        txn_t a;
        txn_t b;
        a = mk(1'b1, 1'b0, 10'h010, 8'h11, 0, 8'h00, 0);
        b = mk(1'b1, 1'b1, 10'h020, 8'h22, 0, 8'h00, 0);
        run_txn(a, 1'b1, b);
        run_txn(b, 1'b1, a);
        run_txn(a, 1'b0, b);
    endtask

    task automatic test_reset_in_wait();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_rom   = 1'b1;
        req_addr  = 10'h2C3;
        req_wdata = 8'h44;
        @(negedge phi2);
        req_valid = 1'b0;
        bus_oe    = 1'b0;
        repeat (3) @(negedge phi2);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bus_cs1_n, bus_we_n, bus_rs_n, rsp_valid, req_ready, bus_addr}
            !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h0}) begin
            n_fail++;
            $display("FAIL reset_in_wait: cs=%b we=%b rs=%b rv=%b rr=%b addr=%h, required 1 1 1 0 0 000",
                     bus_cs1_n, bus_we_n, bus_rs_n, rsp_valid, req_ready, bus_addr);
        end
        @(negedge phi2);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus_oe    = 1'($urandom);
            bus_rdata = 8'($urandom);
            rsp_ready = 1'($urandom);
            @(negedge phi2);
            n_chk++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || bus_cs1_n !== 1'b1) begin
                n_fail++;
                $display("FAIL no_stale_rsp i=%0d: rsp_valid=%b req_ready=%b cs1_n=%b, required 0 1 1",
                         i, rsp_valid, req_ready, bus_cs1_n);
            end
        end
        bus_oe    = 1'b0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        txn_t q[$];
        txn_t t;
        for (int i = 0; i < 40; i++) begin
            t.we      = 1'($urandom);
            t.rom     = 1'($urandom);
            t.addr    = 10'($urandom);
            t.wd      = 8'($urandom);
            t.oe_dly  = (($urandom_range(0, 4) == 0) ? NO_OE : int'($urandom_range(0, TIMEOUT - 1)));
            t.rd      = 8'($urandom);
            t.rdy_dly = int'($urandom_range(0, 3));
            q.push_back(t);
        end
        for (int i = 0; i < 40; i++) begin
            if (i < 39) begin
                run_txn(q[i], 1'($urandom), q[i + 1]);
            end else begin
                run_txn(q[i], 1'b0, q[0]);
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_backpressure();
        test_rom();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
